sobel_window_buffer: RTL and testbench

Parametrised successor to the fixed-size Sobel line buffer. It accepts a raster pixel stream, typically the UART receiver's bytes. It stores lines in four rotating line RAMs and emits one 3x3 window per cycle for every interior column. It also tracks the output line count per frame, pulses a frame-done flag, flushes the two trailing lines at frame end, and flags input overflow.

---
 rtl/sobel_window_buffer.sv | 183 ++++++++++++++++++
 tb/tb_sobel_window_buffer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_buffer.sv
// Raster pixel stream in, one 3x3 window per interior column out. Lines live in
// four rotating line RAMs. Rows are counted per frame, and the two trailing lines are flushed at frame end.
module sobel_window_buffer #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int PIX_W      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [PIX_W-1:0]              pix_in,
    input  logic                          pix_valid,
    output logic [9*PIX_W-1:0]            window_out,
    output logic                          window_valid,
    output logic [$clog2(IMG_HEIGHT)-1:0] line_counter,
    output logic                          frame_done,
    output logic                          overflow
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int LW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] LAST_COL       = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] FIRST_FULL_COL = CW'(2);
    localparam logic [LW-1:0] LAST_ROW       = LW'(IMG_HEIGHT - 3);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    logic [PIX_W-1:0] r_mem [0:3][0:IMG_WIDTH-1];

    logic [CW-1:0]    r_wr_col;
    logic [1:0]       r_wr_sel;
    logic [2:0]       r_filled;
    logic             r_overflow;

    state_t           r_state;
    logic [CW-1:0]    r_rd_col;
    logic [1:0]       r_rd_sel;
    logic             r_drain_cnt;
    logic             r_window_valid;
    logic             r_frame_done;
    logic [LW-1:0]    r_line_counter;

    // Column 2 of the window is the RAM read register itself; 1 and 0 are its history.
    logic [PIX_W-1:0] r_col0 [0:2];
    logic [PIX_W-1:0] r_col1 [0:2];
    logic [PIX_W-1:0] r_col2 [0:2];

    logic             w_accept;
    logic             w_line_done;
    logic             w_row_end;
    logic             w_last_row;
    logic [2:0]       w_retire;
    logic [2:0]       w_filled_next;

    // Write acceptance, row-end detection and net line-count update.
    always_comb begin
        w_accept      = pix_valid && (r_filled < 3'd4);
        w_line_done   = w_accept && (r_wr_col == LAST_COL);
        w_row_end     = (r_state == READ) && (r_rd_col == LAST_COL);
        w_last_row    = (r_line_counter == LAST_ROW);
        if (w_row_end) begin
            w_retire = w_last_row ? 3'd3 : 3'd1;
        end else begin
            w_retire = 3'd0;
        end
        w_filled_next = r_filled + {2'b00, w_line_done} - w_retire;
    end

    // Write pointers, stored-line count and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_col   <= '0;
            r_wr_sel   <= 2'd0;
            r_filled   <= 3'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                if (r_wr_col == LAST_COL) begin
                    r_wr_col <= '0;
                    r_wr_sel <= r_wr_sel + 2'd1;
                end else begin
                    r_wr_col <= r_wr_col + CW'(1);
                end
            end
            if (pix_valid && !w_accept) begin
                r_overflow <= 1'b1;
            end
            r_filled <= w_filled_next;
        end
    end

    // Line RAM write port; the write buffer is never one of the three being read.
    always_ff @(posedge clk) begin
        if (w_accept && !reset) begin
            r_mem[r_wr_sel][r_wr_col] <= pix_in;
        end
    end

    // Synchronous three-row read and window column shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 3; r++) begin
                r_col0[r] <= '0;
                r_col1[r] <= '0;
                r_col2[r] <= '0;
            end
        end else if (r_state == READ) begin
            for (int r = 0; r < 3; r++) begin
                r_col2[r] <= r_mem[r_rd_sel + 2'(r)][r_rd_col];
                r_col1[r] <= r_col2[r];
                r_col0[r] <= r_col1[r];
            end
        end
    end

    // Read FSM with registered window_valid, line_counter and frame_done.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_rd_col       <= '0;
            r_rd_sel       <= 2'd0;
            r_drain_cnt    <= 1'b0;
            r_window_valid <= 1'b0;
            r_frame_done   <= 1'b0;
            r_line_counter <= '0;
        end else begin
            r_window_valid <= 1'b0;
            r_frame_done   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_filled >= 3'd3) begin
                        r_state  <= READ;
                        r_rd_col <= '0;
                    end
                end
                READ: begin
                    // Column rd_col lands in c=2 this edge; c=0 holds rd_col-2.
                    r_window_valid <= (r_rd_col >= FIRST_FULL_COL);
                    if (w_row_end) begin
                        r_state     <= DRAIN;
                        r_drain_cnt <= 1'b0;
                        r_rd_sel    <= r_rd_sel + (w_last_row ? 2'd3 : 2'd1);
                        if (w_last_row) begin
                            r_line_counter <= '0;
                            r_frame_done   <= 1'b1;
                        end else begin
                            r_line_counter <= r_line_counter + LW'(1);
                        end
                    end else begin
                        r_rd_col <= r_rd_col + CW'(1);
                    end
                end
                DRAIN: begin
                    if (r_drain_cnt) begin
                        r_state <= IDLE;
                    end else begin
                        r_drain_cnt <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Pack window registers: field 3*r+c holds row r, column c.
    always_comb begin
        window_out = '0;
        for (int r = 0; r < 3; r++) begin
            window_out[PIX_W*(3*r+0) +: PIX_W] = r_col0[r];
            window_out[PIX_W*(3*r+1) +: PIX_W] = r_col1[r];
            window_out[PIX_W*(3*r+2) +: PIX_W] = r_col2[r];
        end
        window_valid = r_window_valid;
        line_counter = r_line_counter;
        frame_done   = r_frame_done;
        overflow     = r_overflow;
    end

endmodule

// File: tb/tb_sobel_window_buffer.sv
// Bench for sobel_window_buffer (8x6 frames): directed and random streams checked
// each cycle against a timestamped line-queue model, plus literal window pins.
`timescale 1ns/1ps
module tb_sobel_window_buffer;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int PW = 8;
    localparam int LW = $clog2(H);
    localparam logic [9*PW-1:0] FIRST_WIN = 72'h22_21_20_12_11_10_02_01_00;

    typedef logic [W*PW-1:0] line_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [PW-1:0]     pix_in = '0;
    logic              pix_valid = 1'b0;
    logic [9*PW-1:0]   window_out;
    logic              window_valid;
    logic [LW-1:0]     line_counter;
    logic              frame_done;
    logic              overflow;

    sobel_window_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) dut (
        .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid),
        .window_out(window_out), .window_valid(window_valid),
        .line_counter(line_counter), .frame_done(frame_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model: complete lines queue up; a row read starts when the reader is free and
    // three lines are stored, shows windows 3..W edges later, then retires lines.
    line_t           store[$];
    line_t           part;
    int              wcol;
    line_t           snap [3];
    bit              row_on;
    int              s_edge;
    int              free_at;
    int              cyc = 0;
    bit              m_started = 1'b0;
    bit              m_rst_now;
    bit              m_valid;
    logic [9*PW-1:0] m_win;
    int              m_lc;
    bit              m_fd;
    bit              m_ovf;

    always @(posedge clk) begin : model
        int  pre;
        int  k;
        bit  retire;
        bit  last;
        cyc = cyc + 1;
        if (reset) begin
            m_started = 1'b1;
            m_rst_now = 1'b1;
            store.delete();
            part = '0;
            wcol = 0;
            row_on = 1'b0;
            free_at = cyc + 1;
            m_lc = 0;
            m_fd = 1'b0;
            m_ovf = 1'b0;
            m_valid = 1'b0;
        end else begin
            m_rst_now = 1'b0;
            pre = store.size();
            retire = row_on && (cyc == s_edge + W);
            if (!row_on && cyc >= free_at && pre >= 3) begin
                row_on = 1'b1;
                s_edge = cyc;
                for (int r = 0; r < 3; r++) snap[r] = store[r];
            end
            m_valid = row_on && (cyc >= s_edge + 3) && (cyc <= s_edge + W);
            if (m_valid) begin
                k = cyc - s_edge - 3;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        m_win[PW*(3*r+c) +: PW] = snap[r][PW*(k+c) +: PW];
            end
            if (pix_valid) begin
                if (pre < 4) begin
                    part[PW*wcol +: PW] = pix_in;
                    wcol = wcol + 1;
                    if (wcol == W) begin
                        store.push_back(part);
                        wcol = 0;
                    end
                end else begin
                    m_ovf = 1'b1;
                end
            end
            m_fd = 1'b0;
            if (retire) begin
                last = (m_lc == H - 3);
                m_fd = last;
                m_lc = last ? 0 : m_lc + 1;
                for (int i = 0; i < (last ? 3 : 1); i++) void'(store.pop_front());
                row_on = 1'b0;
                free_at = s_edge + W + 3;
            end
        end
    end

    // Log of DUT windows since the last reset, for the literal pins.
    logic [9*PW-1:0] wins[$];
    int              lcs[$];
    bit              fds[$];
    int              win_cnt;
    int              first_valid_cyc;
    int              last_acc;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic cmp_cycle();
        if (m_started) begin
            if (m_rst_now) begin
                wins.delete();
                lcs.delete();
                fds.delete();
                win_cnt = 0;
            end
            check("window_valid", 128'(window_valid), 128'(m_valid));
            check("line_counter", 128'(line_counter), 128'(m_lc));
            check("frame_done", 128'(frame_done), 128'(m_fd));
            check("overflow", 128'(overflow), 128'(m_ovf));
            if (m_valid && window_valid) check("window_out", 128'(window_out), 128'(m_win));
            if (window_valid) begin
                win_cnt++;
                if (win_cnt == 1) first_valid_cyc = cyc;
                wins.push_back(window_out);
                lcs.push_back(int'(line_counter));
                fds.push_back(frame_done);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        pix_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_pix(input int row, input int col);
        pix_valid = 1'b1;
        pix_in = PW'(row * 16 + col);
        tick();
        last_acc = cyc;
        pix_valid = 1'b0;
    endtask

    task automatic send_row(input int row, input int gap);
        for (int c = 0; c < W; c++) send_pix(row, c);
        idle(gap);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pix_valid = 1'b0;
        pix_in = '0;
        tick();
        tick();
        check("rst window_out", 128'(window_out), 128'(0));
        check("rst window_valid", 128'(window_valid), 128'(0));
        check("rst line_counter", 128'(line_counter), 128'(0));
        check("rst frame_done", 128'(frame_done), 128'(0));
        check("rst overflow", 128'(overflow), 128'(0));
        reset = 1'b0;
    endtask

    function automatic logic [9*PW-1:0] win_at(input int i);
        return (i < wins.size()) ? wins[i] : '0;
    endfunction

    function automatic int lc_at(input int i);
        return (i < lcs.size()) ? lcs[i] : -1;
    endfunction

    function automatic int fd_count();
        int n = 0;
        foreach (fds[i]) if (fds[i]) n++;
        return n;
    endfunction

    initial begin : main
        int e_fill;
        int n;
        logic [9*PW-1:0] w;

        // Fill then full frame, rows spaced one read period apart.
        do_reset();
        for (int r = 0; r < 3; r++) send_row(r, 4);
        e_fill = last_acc;
        for (int r = 3; r < 6; r++) send_row(r, 4);
        idle(30);
        check("fill first window", 128'(win_at(0)), 128'(FIRST_WIN));
        w = win_at(5);
        check("fill 6th window top", 128'(w[23:0]), 128'(24'h070605));
        check("fill first valid latency", 128'(first_valid_cyc - e_fill), 128'(4));
        check("frame window count", 128'(win_cnt), 128'(24));
        check("lc row1", 128'(lc_at(5)), 128'(1));
        check("lc row2", 128'(lc_at(11)), 128'(2));
        check("lc row3", 128'(lc_at(17)), 128'(3));
        check("lc row4 wrap", 128'(lc_at(23)), 128'(0));
        check("frame_done count", 128'(fd_count()), 128'(1));
        check("frame_done on 24th", 128'(fds.size() == 24 && fds[23]), 128'(1));

        // Second frame back to back: no leftover lines.
        for (int r = 0; r < 6; r++) send_row(r, 4);
        idle(30);
        check("frame2 window count", 128'(win_cnt), 128'(48));
        check("frame2 first window", 128'(win_at(24)), 128'(FIRST_WIN));
        check("frame_done count 2", 128'(fd_count()), 128'(2));

        // Sparse input at one pixel per 434 cycles.
        do_reset();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < W; c++) begin
                send_pix(r, c);
                idle(433);
            end
        idle(20);
        check("sparse window count", 128'(win_cnt), 128'(24));
        check("sparse first window", 128'(win_at(0)), 128'(FIRST_WIN));
        check("sparse lc seq", 128'({lc_at(5), lc_at(11), lc_at(17), lc_at(23)}), 128'({32'd1, 32'd2, 32'd3, 32'd0}));
        check("sparse overflow", 128'(overflow), 128'(0));

        // Dense burst: four lines fit, the first pixel of the fifth line is dropped.
        do_reset();
        for (int r = 0; r < 4; r++) send_row(r, 0);
        check("burst no overflow", 128'(overflow), 128'(0));
        send_pix(4, 0);
        check("overflow set", 128'(overflow), 128'(1));
        for (int c = 1; c < W; c++) send_pix(4, c);
        send_row(5, 0);
        idle(40);
        check("overflow sticky", 128'(overflow), 128'(1));

        // Reset during the 3rd window of a row while the stream keeps running.
        n = 0;
        for (int i = 0; i < 200 && n < 3; i++) begin
            pix_valid = 1'b1;
            pix_in = PW'($urandom);
            tick();
            if (window_valid) n++;
        end
        check("mid-row window wait", 128'(n), 128'(3));
        reset = 1'b1;
        pix_valid = 1'b0;
        tick();
        check("midrst window_valid", 128'(window_valid), 128'(0));
        check("midrst line_counter", 128'(line_counter), 128'(0));
        check("midrst frame_done", 128'(frame_done), 128'(0));
        check("midrst overflow", 128'(overflow), 128'(0));
        reset = 1'b0;
        tick();
        for (int r = 0; r < 3; r++) send_row(r, 4);
        idle(20);
        check("post-reset window count", 128'(win_cnt), 128'(6));
        check("post-reset first window", 128'(win_at(0)), 128'(FIRST_WIN));

        // Random valid pattern and pixel values against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            pix_valid = ($urandom_range(0, 99) < 70);
            pix_in = PW'($urandom);
            tick();
        end
        idle(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
